timer_ctrl_fsm: RTL and testbench
=================================

// Module: timer_ctrl_fsm
// PURPOSE
//  Sequencing controller for the 8-bit APB timer counter. It turns APB register writes (TCR/TDR/TSR)
//  into counter control: load, count-enable tick, direction. Sits between the APB register decode
//  and the counter/comparator pair. Latches comparator overflow/underflow pulses into sticky TSR bits
//  and drives the timer interrupt.
// PARAMETERS
//  CNT_W  8  counter / reload data width
//  PSC_W  4  prescaler counter width (must hold max divide-1 = 15)
// PORTS
//  PCLK          in   1      system clock, all logic on rising edge
//  PRESET        in   1      asynchronous, active-high reset
//  tcr_wr        in   1      1-cycle write strobe for TCR
//  tcr_wdata     in   8      [7]=LOAD req (self-clearing) [6]=rsvd [5]=DIR(0 up,1 down) [4]=EN
//                            [3]=OVF_IE [2]=UDF_IE [1:0]=CKS (00:/2 01:/4 10:/8 11:/16)
//  tdr           in   CNT_W  reload value from TDR
//  tsr_clr       in   2      write-1-to-clear strobes: [0]=OVF, [1]=UDF (1-cycle)
//  ovf_in        in   1      comparator overflow pulse (FF->00)
//  udf_in        in   1      comparator underflow pulse (00->FF)
//  cnt_load      out  1      1-cycle load pulse to counter
//  cnt_load_val  out  CNT_W  value to load; valid when cnt_load=1
//  cnt_tick      out  1      1-cycle count-enable pulse
//  cnt_dir       out  1      registered TCR.DIR
//  tcr_q         out  8      TCR readback; bit7 always reads 0
//  tsr           out  2      sticky status: [0]=OVF [1]=UDF
//  irq           out  1      (tsr[0]&OVF_IE)|(tsr[1]&UDF_IE), registered
//  state         out  2      FSM state, for debug/readback
// BEHAVIOUR
//  Reset: state=IDLE, TCR=8'h00, tsr=2'b00, all pulses 0, cnt_load_val=0, psc=0, irq=0.
//  TCR: on tcr_wr, bits [5:0] latch at the edge. LOAD is not stored; it raises load_pend.
//  FSM states: IDLE=0, LOAD=1, RUN=2.
//   IDLE: tcr_wr with LOAD=1 -> LOAD. tcr_wr with EN=1 and LOAD=0 -> RUN.
//   LOAD: exactly one cycle. cnt_load=1 and cnt_load_val=tdr, sampled that cycle.
//         Next state is RUN if EN=1, else IDLE.
//   RUN: prescaler counts. Write with EN=0 -> IDLE. Write with LOAD=1 -> LOAD.
//        LOAD has priority over EN=0: a write of 8'h80 gives LOAD then IDLE.
//  Latency: tcr_wr at edge N -> LOAD state (cnt_load high) in cycle N+1 -> RUN from N+2.
//  Prescaler: div = 2<<CKS. psc clears on entry to RUN, on any CKS change and in IDLE/LOAD.
//   In RUN, psc increments every cycle. When psc==div-1: cnt_tick=1 and psc wraps to 0.
//   So the first tick is in the div-th RUN cycle, then one tick every div cycles.
//  cnt_tick is never asserted in the same cycle as cnt_load.
//  DIR and CKS writes take effect in the next cycle. A DIR change does not reset psc.
//  TSR: set on ovf_in/udf_in in any state. Set dominates a same-cycle tsr_clr on that bit.
//   Bits stay set until cleared. irq follows TSR/IE with one cycle of delay.
//  Writes with EN=1 while in RUN and LOAD=0 only update fields; the state stays RUN.
//  Async reset mid-RUN or mid-LOAD: immediate return to reset values. No load pulse is emitted.
// STRUCTURE
//  Package timer_pkg holds:
//   TCR bit-index localparams (LOAD=7, DIR=5, EN=4, OVF_IE=3, UDF_IE=2, CKS=1:0);
//   FSM state encodings (IDLE/LOAD/RUN);
//   CKS encodings and TSR bit indices.
//  Sub-module timer_prescaler: inputs clr, en, cks; output tick. Instanced once.
//  The FSM, TCR, TSR and irq logic stay in this module.
// TESTING
//  1 Reset, then tdr=8'hF0, write TCR=8'h90 (LOAD+EN, /2) -> cnt_load=1 with cnt_load_val=F0 at N+1;
//    RUN at N+2; cnt_tick on RUN cycles 2,4,6,...
//  2 In RUN write TCR=8'h13 (/16) -> psc clears; the next tick is exactly 16 cycles after the write.
//  3 ovf_in pulse with OVF_IE=1 -> tsr=2'b01 on the next edge, irq=1 one cycle later.
//    tsr_clr=2'b01 -> tsr=0, then irq=0.
//  4 ovf_in and tsr_clr[0] in the same cycle -> tsr[0] stays 1.
//    udf_in with UDF_IE=0 -> tsr[1]=1 and irq=0.
//  5 In RUN write TCR=8'h80 -> one cnt_load pulse, then IDLE, no further ticks.
//    Then write 8'h10 -> RUN without a load.
//  6 Assert PRESET during the LOAD cycle -> cnt_load drops at once; state=IDLE, tcr_q=0, tsr=0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the APB timer control block: TCR/TSR field positions,
// FSM state encodings and clock-select encodings.
package timer_pkg;

    localparam int TCR_LOAD   = 7;
    localparam int TCR_RSVD   = 6;
    localparam int TCR_DIR    = 5;
    localparam int TCR_EN     = 4;
    localparam int TCR_OVF_IE = 3;
    localparam int TCR_UDF_IE = 2;
    localparam int TCR_CKS_HI = 1;
    localparam int TCR_CKS_LO = 0;

    localparam int TSR_OVF = 0;
    localparam int TSR_UDF = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CKS_DIV2  = 2'b00,
        CKS_DIV4  = 2'b01,
        CKS_DIV8  = 2'b10,
        CKS_DIV16 = 2'b11
    } cks_e;

    // Terminal prescaler value (divide - 1) for a given clock select.
    function automatic logic [3:0] psc_terminal(input logic [1:0] cks);
        logic [3:0] term;
        term = 4'd15;
        case (cks_e'(cks))
            CKS_DIV2:  term = 4'd1;
            CKS_DIV4:  term = 4'd3;
            CKS_DIV8:  term = 4'd7;
            CKS_DIV16: term = 4'd15;
            default:   term = 4'd15;
        endcase
        return term;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler for the timer counter: divides the system clock by 2/4/8/16
// and emits a one-cycle tick at the terminal value while enabled.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int PSC_W = 4
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       clr,
    input  logic       en,
    input  logic [1:0] cks,
    output logic       tick
);

    logic [PSC_W-1:0] psc_q;
    logic [PSC_W-1:0] psc_d;
    logic [PSC_W-1:0] term;

    assign term = PSC_W'(psc_terminal(cks));

    // Held at zero whenever disabled so every entry to counting starts a full period.
    always_comb begin
        psc_d = psc_q;
        if (clr || !en) begin
            psc_d = '0;
        end else if (psc_q == term) begin
            psc_d = '0;
        end else begin
            psc_d = psc_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end

    assign tick = en && (psc_q == term);

endmodule

// File: rtl/timer_ctrl_fsm.sv
// Timer sequencing controller: turns TCR writes into counter load/tick/direction
// control, keeps sticky OVF/UDF status and drives the registered timer interrupt.
module timer_ctrl_fsm
    import timer_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int PSC_W = 4
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             tcr_wr,
    input  logic [7:0]       tcr_wdata,
    input  logic [CNT_W-1:0] tdr,
    input  logic [1:0]       tsr_clr,
    input  logic             ovf_in,
    input  logic             udf_in,
    output logic             cnt_load,
    output logic [CNT_W-1:0] cnt_load_val,
    output logic             cnt_tick,
    output logic             cnt_dir,
    output logic [7:0]       tcr_q,
    output logic [1:0]       tsr,
    output logic             irq,
    output logic [1:0]       state
);

    state_e     state_q;
    logic       load_q;
    logic [5:0] ctrl_q;
    logic [5:0] ctrl_d;
    logic [1:0] tsr_q;
    logic [1:0] tsr_d;
    logic       irq_q;
    logic       irq_d;

    logic       load_pend;
    logic       en_next;
    logic       cks_chg;
    logic       run_en;
    logic       psc_tick;
    logic       unused_rsvd;

    assign unused_rsvd = tcr_wdata[TCR_RSVD];

    assign load_pend = tcr_wr && tcr_wdata[TCR_LOAD];
    assign en_next   = tcr_wr ? tcr_wdata[TCR_EN] : ctrl_q[TCR_EN];
    assign cks_chg   = tcr_wr &&
                       (tcr_wdata[TCR_CKS_HI:TCR_CKS_LO] != ctrl_q[TCR_CKS_HI:TCR_CKS_LO]);
    assign run_en    = (state_q == ST_RUN);

    always_comb begin
        ctrl_d = ctrl_q;
        if (tcr_wr) begin
            ctrl_d = tcr_wdata[5:0];
        end
    end

    // Status set wins over a same-cycle write-1-to-clear.
    always_comb begin
        tsr_d = tsr_q;
        tsr_d[TSR_OVF] = ovf_in | (tsr_q[TSR_OVF] & ~tsr_clr[TSR_OVF]);
        tsr_d[TSR_UDF] = udf_in | (tsr_q[TSR_UDF] & ~tsr_clr[TSR_UDF]);
    end

    always_comb begin
        irq_d = (tsr_q[TSR_OVF] & ctrl_q[TCR_OVF_IE]) |
                (tsr_q[TSR_UDF] & ctrl_q[TCR_UDF_IE]);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ctrl_q <= '0;
            tsr_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            tsr_q  <= tsr_d;
            irq_q  <= irq_d;
        end
    end

    // A LOAD request always wins over an EN=0 in the same write.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= ST_IDLE;
            load_q  <= 1'b0;
        end else begin
            load_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_pend) begin
                        state_q <= ST_LOAD;
                        load_q  <= 1'b1;
                    end else if (tcr_wr && tcr_wdata[TCR_EN]) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_LOAD: begin
                    if (load_pend) begin
                        state_q <= ST_LOAD;
                        load_q  <= 1'b1;
                    end else if (en_next) begin
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (load_pend) begin
                        state_q <= ST_LOAD;
                        load_q  <= 1'b1;
                    end else if (tcr_wr && !tcr_wdata[TCR_EN]) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    timer_prescaler #(
        .PSC_W(PSC_W)
    ) u_prescaler (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .clr   (cks_chg),
        .en    (run_en),
        .cks   (ctrl_q[TCR_CKS_HI:TCR_CKS_LO]),
        .tick  (psc_tick)
    );

    assign cnt_load     = load_q;
    assign cnt_load_val = load_q ? tdr : '0;
    assign cnt_tick     = psc_tick;
    assign cnt_dir      = ctrl_q[TCR_DIR];
    assign tcr_q        = {2'b00, ctrl_q};
    assign tsr          = tsr_q;
    assign irq          = irq_q;
    assign state        = state_q;

endmodule

// File: tb/tb_timer_ctrl_fsm.sv
// Directed self-checking bench for timer_ctrl_fsm: a vector table for the
// per-cycle behaviour plus hand-written multi-cycle sequences.
module tb_timer_ctrl_fsm;

    logic       PCLK;
    logic       PRESET;
    logic       tcr_wr;
    logic [7:0] tcr_wdata;
    logic [7:0] tdr;
    logic [1:0] tsr_clr;
    logic       ovf_in;
    logic       udf_in;
    logic       cnt_load;
    logic [7:0] cnt_load_val;
    logic       cnt_tick;
    logic       cnt_dir;
    logic [7:0] tcr_q;
    logic [1:0] tsr;
    logic       irq;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    timer_ctrl_fsm #(.CNT_W(8), .PSC_W(4)) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .tcr_wr      (tcr_wr),
        .tcr_wdata   (tcr_wdata),
        .tdr         (tdr),
        .tsr_clr     (tsr_clr),
        .ovf_in      (ovf_in),
        .udf_in      (udf_in),
        .cnt_load    (cnt_load),
        .cnt_load_val(cnt_load_val),
        .cnt_tick    (cnt_tick),
        .cnt_dir     (cnt_dir),
        .tcr_q       (tcr_q),
        .tsr         (tsr),
        .irq         (irq),
        .state       (state)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic       wr;
        logic [7:0] wdata;
        logic [1:0] clr;
        logic       ovf;
        logic       udf;
        logic       exp_load;
        logic [7:0] exp_val;
        logic       exp_tick;
        logic [1:0] exp_state;
        logic [7:0] exp_tcr;
        logic [1:0] exp_tsr;
        logic       exp_irq;
        logic       exp_dir;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic wr, input logic [7:0] wd, input logic [1:0] clr,
                                input logic ovf, input logic udf, input logic ld,
                                input logic [7:0] val, input logic tk, input logic [1:0] st,
                                input logic [7:0] tcr, input logic [1:0] ts, input logic ir,
                                input logic dr);
        vec_t v;
        v.wr = wr; v.wdata = wd; v.clr = clr; v.ovf = ovf; v.udf = udf;
        v.exp_load = ld; v.exp_val = val; v.exp_tick = tk; v.exp_state = st;
        v.exp_tcr = tcr; v.exp_tsr = ts; v.exp_irq = ir; v.exp_dir = dr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [7:0] wd, input logic [1:0] clr,
                         input logic ovf, input logic udf);
        tcr_wr = wr; tcr_wdata = wd; tsr_clr = clr; ovf_in = ovf; udf_in = udf;
    endtask

    initial begin
        int cnt;
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int bad;
        // wr wdata clr ovf udf | load val tick state tcr tsr irq dir
        vecs[0]  = mk(1'b1, 8'h90, 2'b00, 1'b0, 1'b0, 1'b1, 8'hF0, 1'b0, 2'd1, 8'h10, 2'b00, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd2, 8'h10, 2'b00, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd2, 8'h10, 2'b00, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd2, 8'h10, 2'b00, 1'b0, 1'b0);
        vecs[4]  = mk(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd2, 8'h10, 2'b00, 1'b0, 1'b0);
        vecs[5]  = mk(1'b1, 8'h18, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd2, 8'h18, 2'b00, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd2, 8'h18, 2'b01, 1'b0, 1'b0);
        vecs[7]  = mk(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd2, 8'h18, 2'b01, 1'b1, 1'b0);
        vecs[8]  = mk(1'b0, 8'h00, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd2, 8'h18, 2'b00, 1'b1, 1'b0);
        vecs[9]  = mk(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd2, 8'h18, 2'b00, 1'b0, 1'b0);
        vecs[10] = mk(1'b0, 8'h00, 2'b01, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd2, 8'h18, 2'b01, 1'b0, 1'b0);
        vecs[11] = mk(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd2, 8'h18, 2'b01, 1'b1, 1'b0);
        vecs[12] = mk(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd2, 8'h18, 2'b11, 1'b1, 1'b0);
        vecs[13] = mk(1'b0, 8'h00, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd2, 8'h18, 2'b10, 1'b1, 1'b0);
        vecs[14] = mk(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd2, 8'h18, 2'b10, 1'b0, 1'b0);
        vecs[15] = mk(1'b0, 8'h00, 2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd2, 8'h18, 2'b00, 1'b0, 1'b0);
        vecs[16] = mk(1'b1, 8'h38, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd2, 8'h38, 2'b00, 1'b0, 1'b1);
        vecs[17] = mk(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd2, 8'h38, 2'b00, 1'b0, 1'b1);
        vecs[18] = mk(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd2, 8'h38, 2'b00, 1'b0, 1'b1);

        PRESET = 1'b1;
        tdr    = 8'hF0;
        drive(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
        step();
        step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_tcr", 32'(tcr_q), 32'h00);
        chk("rst_tsr", 32'(tsr), 32'd0);
        chk("rst_load", 32'(cnt_load), 32'd0);
        chk("rst_load_val", 32'(cnt_load_val), 32'd0);
        chk("rst_tick", 32'(cnt_tick), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_dir", 32'(cnt_dir), 32'd0);
        PRESET = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].wr, vecs[i].wdata, vecs[i].clr, vecs[i].ovf, vecs[i].udf);
            step();
            chk($sformatf("v%0d_load", i), 32'(cnt_load), 32'(vecs[i].exp_load));
            chk($sformatf("v%0d_val", i), 32'(cnt_load_val), 32'(vecs[i].exp_val));
            chk($sformatf("v%0d_tick", i), 32'(cnt_tick), 32'(vecs[i].exp_tick));
            chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
            chk($sformatf("v%0d_tcr", i), 32'(tcr_q), 32'(vecs[i].exp_tcr));
            chk($sformatf("v%0d_tsr", i), 32'(tsr), 32'(vecs[i].exp_tsr));
            chk($sformatf("v%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
            chk($sformatf("v%0d_dir", i), 32'(cnt_dir), 32'(vecs[i].exp_dir));
        end

        // Switch to /16 mid-run: next tick lands in the 16th cycle after the write.
        drive(1'b1, 8'h13, 2'b00, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
        chk("div16_tcr", 32'(tcr_q), 32'h13);
        cnt = (cnt_tick === 1'b1) ? 1 : 0;
        for (int k = 2; k <= 15; k++) begin
            step();
            if (cnt_tick === 1'b1) cnt++;
        end
        chk("div16_no_early_tick", 32'(cnt), 32'd0);
        step();
        chk("div16_tick_at_16", 32'(cnt_tick), 32'd1);
        step();
        chk("div16_tick_17", 32'(cnt_tick), 32'd0);

        // LOAD with EN=0 from RUN: one load pulse, then IDLE with no ticks.
        tdr = 8'hA5;
        drive(1'b1, 8'h80, 2'b00, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
        chk("ld80_state", 32'(state), 32'd1);
        chk("ld80_load", 32'(cnt_load), 32'd1);
        chk("ld80_val", 32'(cnt_load_val), 32'hA5);
        chk("ld80_tick", 32'(cnt_tick), 32'd0);
        chk("ld80_tcr_bit7", 32'(tcr_q), 32'h00);
        step();
        chk("ld80_idle", 32'(state), 32'd0);
        chk("ld80_load_drop", 32'(cnt_load), 32'd0);
        cnt = 0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (cnt_tick !== 1'b0) cnt++;
            if (state !== 2'd0 || cnt_load !== 1'b0) bad++;
        end
        chk("idle_no_ticks", 32'(cnt), 32'd0);
        chk("idle_stays", 32'(bad), 32'd0);
        drive(1'b1, 8'h10, 2'b00, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
        chk("en_run_state", 32'(state), 32'd2);
        chk("en_run_noload", 32'(cnt_load), 32'd0);
        chk("en_run_tick1", 32'(cnt_tick), 32'd0);
        step();
        chk("en_run_tick2", 32'(cnt_tick), 32'd1);

        // Async reset in the middle of a LOAD cycle.
        tdr = 8'h5A;
        drive(1'b1, 8'h90, 2'b00, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
        chk("rl_load", 32'(cnt_load), 32'd1);
        chk("rl_val", 32'(cnt_load_val), 32'h5A);
        chk("rl_tsr_pre", 32'(tsr), 32'b01);
        #3;
        PRESET = 1'b1;
        #1;
        chk("rl_load_drop", 32'(cnt_load), 32'd0);
        chk("rl_state", 32'(state), 32'd0);
        chk("rl_tcr", 32'(tcr_q), 32'h00);
        chk("rl_tsr", 32'(tsr), 32'd0);
        chk("rl_val_zero", 32'(cnt_load_val), 32'd0);
        step();
        PRESET = 1'b0;
        step();
        chk("rl_post_state", 32'(state), 32'd0);
        chk("rl_post_load", 32'(cnt_load), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
